connect4_turn_controller: RTL and testbench
===========================================

// Module: connect4_turn_controller
// PURPOSE
//  Sequences every move of the Connect-4 game. Latches the selected column on a go press,
//  validates the move, and issues a one-cycle write of the current player's piece into the
//  7x7 cell register bank. It then runs a request/ack handshake with the win checker.
//  Finally it advances the turn or ends the game. Sits between the KEY/SW inputs, the board
//  registers and sequence_recognizer.
// PARAMETERS
//  COLS   7  number of board columns; col_sel bit (COLS-1-i) selects column i
//  ROWS   7  number of board rows; a column is full when its count == ROWS
//  CW     3  width of each column count; must hold ROWS
// PORTS
//  CLOCK_50    in   1          system clock, all state on rising edge
//  resetn      in   1          asynchronous, active-low reset
//  go          in   1          active-high move request (~KEY[0]), asynchronous level
//  col_sel     in   COLS       column switches SW[COLS-1:0]; SW[6] = column 0, highest priority
//  check_ack   in   1          win checker finished evaluating the updated board
//  winner      in   2          checker result: 00 none, 01 player 1, 10 player 2 (valid with ack)
//  cell_we     out  1          one-cycle board write strobe
//  cell_addr   out  6          cell index written = col + COLS*(ROWS-1-count)
//  cell_piece  out  2          piece written: equals turn
//  turn        out  2          player to move: 01 or 10
//  col_counts  out  COLS*CW    packed column fill counts; column i at [i*CW +: CW]
//  check_req   out  1          request win evaluation; held until check_ack
//  illegal     out  1          one-cycle pulse: move rejected
//  busy        out  1          high whenever state != IDLE and not game over
//  game_over   out  1          sticky until reset
//  win_player  out  2          winning player, 00 if none or draw
//  draw        out  1          sticky: board filled with no winner
// BEHAVIOUR
//  Reset (resetn low, async):
//   - state=IDLE, turn=01, all counts=0, move counter=0.
//   - All strobes 0, game_over/draw=0, win_player=00.
//   - A move in flight is abandoned and no write is issued.
//  go path:
//   - Two-flop synchroniser, then rising-edge detect; 2-cycle input latency.
//   - go edges outside IDLE are dropped, not queued.
//  FSM states: IDLE, VALID, WRITE, CHECK, OVER.
//   IDLE:
//    - On a go edge (cycle E), latch the priority-encoded column and its count -> VALID.
//   VALID (E+1):
//    - If no switch is set, or the latched count == ROWS: illegal=1 for this cycle -> IDLE.
//    - Turn and counts are unchanged. Otherwise -> WRITE.
//   WRITE (E+2):
//    - cell_we=1 exactly one cycle, with cell_addr and cell_piece=turn.
//    - Column count +1 and move counter +1 at the end of this cycle -> CHECK.
//   CHECK (from E+3):
//    - check_req=1 and held. Winner is sampled only in a cycle with check_ack=1.
//     - winner!=00: win_player=winner, game_over=1 -> OVER.
//     - else move counter == ROWS*COLS: draw=1, game_over=1 -> OVER.
//     - else toggle turn (01<->10) -> IDLE; check_req falls the cycle after ack.
//    - A check_ack arriving while check_req=0 is ignored.
//   OVER:
//    - Absorbing; ignores go and check_ack. Exit only by reset.
//  Widths and stability:
//   - cell_addr is computed in 6 bits; with COLS=ROWS=7 the range is 0..48.
//   - Counts saturate by construction: a full column is never incremented.
//   - Column and count are latched, so col_sel changes after E do not affect the move.
//   - All outputs are registered; no combinational path from inputs to outputs.
// TESTING
//  1 Reset, col_sel=7'b1000000, go pulse -> cell_we at E+2, addr=42, piece=01;
//    counts[2:0]=1; check_req=1; after ack with winner=00, turn=10.
//  2 Eight go presses in column 3 (each acked, winner=00) -> writes to addr 45,38,31,24,17,10,3;
//    the 8th press gives illegal=1, no cell_we, turn unchanged.
//  3 col_sel=0 and go -> illegal pulse at E+1, state back to IDLE, no write; also
//    col_sel=7'b0100100 -> column 1 chosen (addr 43).
//  4 In CHECK, delay check_ack 5 cycles and pulse go meanwhile -> check_req held for all 5,
//    go ignored; ack with winner=10 -> game_over=1, win_player=10; later go has no effect.
//  5 Fill all 49 cells with winner=00 on every ack -> draw=1 and game_over=1 after the 49th ack.
//  6 Assert resetn low during WRITE and during CHECK -> immediately state IDLE, counts 0,
//    cell_we/check_req=0, turn=01.

Source files
------------

// File: rtl/connect4_turn_controller.sv
// Connect-4 move sequencer: latches a column on go, validates the move,
// writes the piece, handshakes with the win checker and then advances the turn.
module connect4_turn_controller #(
    parameter int COLS = 7,
    parameter int ROWS = 7,
    parameter int CW   = 3
) (
    input  logic                 CLOCK_50,
    input  logic                 resetn,
    input  logic                 go,
    input  logic [COLS-1:0]      col_sel,
    input  logic                 check_ack,
    input  logic [1:0]           winner,
    output logic                 cell_we,
    output logic [5:0]           cell_addr,
    output logic [1:0]           cell_piece,
    output logic [1:0]           turn,
    output logic [COLS*CW-1:0]   col_counts,
    output logic                 check_req,
    output logic                 illegal,
    output logic                 busy,
    output logic                 game_over,
    output logic [1:0]           win_player,
    output logic                 draw
);
    localparam int CELLS = ROWS * COLS;
    localparam int MW    = $clog2(CELLS + 1);
    localparam int CIW   = $clog2(COLS);

    typedef enum logic [2:0] {IDLE, VALID, WRITE, CHECK, OVER} state_t;

    state_t               state_q, state_d;
    logic                 go_s1_q, go_s2_q, go_s3_q;
    logic [CIW-1:0]       col_q, col_d;
    logic [CW-1:0]        lcnt_q, lcnt_d;
    logic                 bad_q, bad_d;
    logic [COLS*CW-1:0]   cnt_q, cnt_d;
    logic [MW-1:0]        moves_q, moves_d;
    logic [1:0]           turn_q, turn_d;
    logic [1:0]           win_q, win_d;
    logic                 draw_q, draw_d;
    logic                 over_q, over_d;
    logic                 go_edge;
    logic [CIW-1:0]       pick;
    logic [CW-1:0]        pick_cnt;

    assign go_edge = go_s2_q & ~go_s3_q;

    // SW[COLS-1] is column 0; lowest column index wins
    always_comb begin
        pick = '0;
        for (int i = COLS - 1; i >= 0; i--) begin
            if (col_sel[COLS-1-i]) pick = CIW'(i);
        end
        pick_cnt = cnt_q[int'(pick)*CW +: CW];
    end

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        lcnt_d  = lcnt_q;
        bad_d   = bad_q;
        cnt_d   = cnt_q;
        moves_d = moves_q;
        turn_d  = turn_q;
        win_d   = win_q;
        draw_d  = draw_q;
        over_d  = over_q;
        unique case (state_q)
            IDLE: begin
                if (go_edge) begin
                    col_d   = pick;
                    lcnt_d  = pick_cnt;
                    bad_d   = ~(|col_sel) || (pick_cnt == CW'(ROWS));
                    state_d = VALID;
                end
            end
            VALID: state_d = bad_q ? IDLE : WRITE;
            WRITE: begin
                cnt_d[int'(col_q)*CW +: CW] = lcnt_q + CW'(1);
                moves_d = moves_q + MW'(1);
                state_d = CHECK;
            end
            CHECK: begin
                if (check_ack) begin
                    if (winner != 2'b00) begin
                        win_d   = winner;
                        over_d  = 1'b1;
                        state_d = OVER;
                    end else if (moves_q == MW'(CELLS)) begin
                        draw_d  = 1'b1;
                        over_d  = 1'b1;
                        state_d = OVER;
                    end else begin
                        turn_d  = (turn_q == 2'b01) ? 2'b10 : 2'b01;
                        state_d = IDLE;
                    end
                end
            end
            OVER:    state_d = OVER;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            go_s1_q <= 1'b0;
            go_s2_q <= 1'b0;
            go_s3_q <= 1'b0;
            col_q   <= '0;
            lcnt_q  <= '0;
            bad_q   <= 1'b0;
            cnt_q   <= '0;
            moves_q <= '0;
            turn_q  <= 2'b01;
            win_q   <= 2'b00;
            draw_q  <= 1'b0;
            over_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            go_s1_q <= go;
            go_s2_q <= go_s1_q;
            go_s3_q <= go_s2_q;
            col_q   <= col_d;
            lcnt_q  <= lcnt_d;
            bad_q   <= bad_d;
            cnt_q   <= cnt_d;
            moves_q <= moves_d;
            turn_q  <= turn_d;
            win_q   <= win_d;
            draw_q  <= draw_d;
            over_q  <= over_d;
        end
    end

    // outputs decode registered state only
    assign cell_we    = (state_q == WRITE);
    assign cell_addr  = 6'(col_q) + 6'(COLS) * (6'(ROWS - 1) - 6'(lcnt_q));
    assign cell_piece = turn_q;
    assign turn       = turn_q;
    assign col_counts = cnt_q;
    assign check_req  = (state_q == CHECK);
    assign illegal    = (state_q == VALID) && bad_q;
    assign busy       = (state_q != IDLE) && (state_q != OVER);
    assign game_over  = over_q;
    assign win_player = win_q;
    assign draw       = draw_q;
endmodule

// File: tb/tb_connect4_turn_controller.sv
// Scoreboard bench for connect4_turn_controller: stimulus queues expected
// writes/illegal pulses, a negedge monitor pops and compares them.
module tb_connect4_turn_controller;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        go = 1'b0;
    logic [6:0]  col_sel = '0;
    logic        check_ack = 1'b0;
    logic [1:0]  winner = 2'b00;
    logic        cell_we;
    logic [5:0]  cell_addr;
    logic [1:0]  cell_piece;
    logic [1:0]  turn;
    logic [20:0] col_counts;
    logic        check_req;
    logic        illegal;
    logic        busy;
    logic        game_over;
    logic [1:0]  win_player;
    logic        draw;

    typedef struct {
        bit         ill;
        logic [5:0] addr;
        logic [1:0] piece;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    connect4_turn_controller dut (
        .CLOCK_50   (clk),
        .resetn     (resetn),
        .go         (go),
        .col_sel    (col_sel),
        .check_ack  (check_ack),
        .winner     (winner),
        .cell_we    (cell_we),
        .cell_addr  (cell_addr),
        .cell_piece (cell_piece),
        .turn       (turn),
        .col_counts (col_counts),
        .check_req  (check_req),
        .illegal    (illegal),
        .busy       (busy),
        .game_over  (game_over),
        .win_player (win_player),
        .draw       (draw)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // monitor: every write or illegal pulse must match the head of the queue
    always @(negedge clk) begin
        if (resetn) begin
            if (cell_we) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: addr %0d piece %0d", cell_addr, cell_piece);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("write_kind", 32'(e.ill), 32'd0);
                    chk("write_addr", 32'(cell_addr), 32'(e.addr));
                    chk("write_piece", 32'(cell_piece), 32'(e.piece));
                end
            end
            if (illegal) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_illegal: got 1 expected 0");
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("illegal_kind", 32'(e.ill), 32'd1);
                end
            end
        end
    end

    task automatic do_reset();
        go = 1'b0;
        check_ack = 1'b0;
        winner = 2'b00;
        @(negedge clk);
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic move(input logic [6:0] sel, input bit exp_ill,
                        input logic [5:0] exp_addr, input logic [1:0] exp_piece,
                        input logic [1:0] win, input int ack_dly, input bit pulse_go);
        exp_t e;
        int got;
        e.ill = exp_ill;
        e.addr = exp_ill ? 6'd0 : exp_addr;
        e.piece = exp_ill ? 2'd0 : exp_piece;
        sb.push_back(e);
        col_sel = sel;
        go = 1'b1;
        got = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (c == 2) go = 1'b0;
            if (illegal) begin got = 1; break; end
            if (check_req) begin got = 2; break; end
        end
        go = 1'b0;
        chk("move_outcome", 32'(got), exp_ill ? 32'd1 : 32'd2);
        if (got == 2) begin
            for (int c = 0; c < ack_dly; c++) begin
                if (pulse_go) go = (c >= 1 && c <= 3);
                chk("req_held", 32'(check_req), 32'd1);
                @(negedge clk);
            end
            go = 1'b0;
            check_ack = 1'b1;
            winner = win;
            @(negedge clk);
            check_ack = 1'b0;
            winner = 2'b00;
            chk("req_drop", 32'(check_req), 32'd0);
        end
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // test 1: reset state and first move in column 0
        do_reset();
        chk("rst_turn", 32'(turn), 32'd1);
        chk("rst_counts", 32'(col_counts), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_over", 32'(game_over), 32'd0);
        chk("rst_draw", 32'(draw), 32'd0);
        chk("rst_win", 32'(win_player), 32'd0);
        chk("rst_req", 32'(check_req), 32'd0);
        chk("rst_we", 32'(cell_we), 32'd0);
        move(7'b1000000, 1'b0, 6'd42, 2'b01, 2'b00, 0, 1'b0);
        chk("t1_turn", 32'(turn), 32'd2);
        chk("t1_counts", 32'(col_counts), 32'd1);
        chk("t1_busy", 32'(busy), 32'd0);

        // test 2: fill column 3, eighth press rejected
        do_reset();
        for (int k = 0; k < 7; k++)
            move(7'b0001000, 1'b0, 6'(45 - 7 * k), (k % 2 == 0) ? 2'b01 : 2'b10,
                 2'b00, 1, 1'b0);
        move(7'b0001000, 1'b1, 6'd0, 2'd0, 2'b00, 0, 1'b0);
        chk("t2_turn", 32'(turn), 32'd2);
        chk("t2_count3", 32'(col_counts[9 +: 3]), 32'd7);
        chk("t2_req", 32'(check_req), 32'd0);

        // test 3: no switch set, then priority of column 1 over column 4
        do_reset();
        move(7'b0000000, 1'b1, 6'd0, 2'd0, 2'b00, 0, 1'b0);
        chk("t3_busy", 32'(busy), 32'd0);
        chk("t3_counts", 32'(col_counts), 32'd0);
        chk("t3_turn", 32'(turn), 32'd1);
        move(7'b0100100, 1'b0, 6'd43, 2'b01, 2'b00, 0, 1'b0);
        chk("t3_count1", 32'(col_counts), 32'h8);

        // test 4: delayed ack with go noise, player 2 wins
        do_reset();
        move(7'b1000000, 1'b0, 6'd42, 2'b01, 2'b10, 5, 1'b1);
        chk("t4_over", 32'(game_over), 32'd1);
        chk("t4_win", 32'(win_player), 32'd2);
        chk("t4_draw", 32'(draw), 32'd0);
        col_sel = 7'b0000001;
        go = 1'b1;
        repeat (3) @(negedge clk);
        go = 1'b0;
        repeat (8) @(negedge clk);
        chk("t4_counts", 32'(col_counts), 32'd1);
        chk("t4_busy", 32'(busy), 32'd0);
        chk("t4_still_over", 32'(game_over), 32'd1);

        // test 5: fill all 49 cells -> draw
        do_reset();
        for (int c = 0; c < 7; c++)
            for (int r = 0; r < 7; r++)
                move(7'b1000000 >> c, 1'b0, 6'(c + 7 * (6 - r)),
                     (((c * 7 + r) % 2) == 0) ? 2'b01 : 2'b10, 2'b00, 0, 1'b0);
        chk("t5_draw", 32'(draw), 32'd1);
        chk("t5_over", 32'(game_over), 32'd1);
        chk("t5_win", 32'(win_player), 32'd0);
        chk("t5_counts", 32'(col_counts), 32'h1FFFFF);

        // test 6a: reset while in WRITE
        do_reset();
        col_sel = 7'b1000000;
        go = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (c == 2) go = 1'b0;
            if (busy) break;
        end
        go = 1'b0;
        @(posedge clk);
        #1 resetn = 1'b0;
        @(negedge clk);
        chk("t6a_we", 32'(cell_we), 32'd0);
        chk("t6a_busy", 32'(busy), 32'd0);
        chk("t6a_counts", 32'(col_counts), 32'd0);
        resetn = 1'b1;
        repeat (3) @(negedge clk);

        // test 6b: reset while in CHECK
        begin
            exp_t e;
            e.ill = 1'b0;
            e.addr = 6'd42;
            e.piece = 2'b01;
            sb.push_back(e);
        end
        go = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (c == 2) go = 1'b0;
            if (check_req) break;
        end
        go = 1'b0;
        chk("t6b_req_on", 32'(check_req), 32'd1);
        resetn = 1'b0;
        #1;
        chk("t6b_req", 32'(check_req), 32'd0);
        chk("t6b_counts", 32'(col_counts), 32'd0);
        chk("t6b_turn", 32'(turn), 32'd1);
        @(negedge clk);
        resetn = 1'b1;
        repeat (3) @(negedge clk);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
